// File: rtl/mac_result_sink.sv
// Collects MAC results into per-block sums, folds every accepted result into a signature and counts a run.
// Define MAC_SINK_MISR_EN to use a CRC-32 style MISR for the signature; by default it is an XOR fold.
module mac_result_sink #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BLOCK_LEN  = 16,
    parameter int unsigned NUM_BLOCKS = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [WIDTH-1:0] blk_data,
    output logic [WIDTH-1:0] signature,
    output logic [31:0]      sample_count,
    output logic [15:0]      block_count,
    output logic             done
);

    localparam int unsigned     BEAT_W        = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BLOCK_LEN - 1);
    localparam logic [15:0]     BLOCKS_TARGET = 16'(NUM_BLOCKS);
    localparam logic [31:0]     POLY          = 32'h04C11DB7;
    localparam logic [WIDTH-1:0] POLY_W       = WIDTH'(POLY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc;
    logic [BEAT_W-1:0]  beat;
    logic [WIDTH-1:0]   sig_next;
    logic               xfer;
    logic               last_beat;
    logic               blk_accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshakes and next-state decode
    always_comb begin
        state_next = state;
        in_ready   = (state == ST_RUN) && (!blk_valid || blk_ready);
        xfer       = in_valid && in_ready;
        last_beat  = xfer && (beat == BEAT_LAST);
        blk_accept = blk_valid && blk_ready;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Finish only once the final block sum has left the output register
                if (blk_accept && !last_beat && (block_count >= BLOCKS_TARGET)) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Signature update for one accepted result
    always_comb begin
`ifdef MAC_SINK_MISR_EN
        sig_next = {signature[WIDTH-2:0], 1'b0} ^ in_data ^ (signature[WIDTH-1] ? POLY_W : '0);
`else
        sig_next = signature ^ in_data;
`endif
    end

    // Accumulator, block output register and run counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            beat         <= '0;
            blk_valid    <= 1'b0;
            blk_data     <= '0;
            signature    <= '0;
            sample_count <= '0;
            block_count  <= '0;
            done         <= 1'b0;
        end else begin
            done <= (state_next == ST_DONE);
            if ((state != ST_RUN) && start) begin
                acc          <= '0;
                beat         <= '0;
                blk_valid    <= 1'b0;
                signature    <= '0;
                sample_count <= '0;
                block_count  <= '0;
            end else if (xfer) begin
                signature <= sig_next;
                if (sample_count != '1) begin
                    sample_count <= sample_count + 32'd1;
                end
                if (last_beat) begin
                    // A completing block overwrites a sum accepted on this same edge
                    acc       <= '0;
                    beat      <= '0;
                    blk_valid <= 1'b1;
                    blk_data  <= acc + in_data;
                    if (block_count != '1) begin
                        block_count <= block_count + 16'd1;
                    end
                end else begin
                    acc  <= acc + in_data;
                    beat <= beat + BEAT_W'(1);
                    if (blk_accept) begin
                        blk_valid <= 1'b0;
                    end
                end
            end else if (blk_accept) begin
                blk_valid <= 1'b0;
            end
        end
    end

endmodule
